// File: rtl/rand_pkg.sv
// rand_pkg: shared state encoding, default sizes and the rejection mask helper
// for the rand_draw random-range front end.
package rand_pkg;

  localparam int unsigned DEF_WIDTH     = 32;
  localparam int unsigned DEF_RANGE_W   = 8;
  localparam int unsigned DEF_SHIFTS    = 32;
  localparam int unsigned DEF_MAX_RETRY = 4;
  localparam int unsigned MASK_W        = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_DIV    = 3'd3,
    ST_DONE   = 3'd4,
    ST_CHECK  = 3'd5
  } draw_state_t;

  // Smallest all-ones mask (2^k - 1) that covers n - 1; n == 0 yields 0.
  function automatic logic [MASK_W-1:0] mask_for(input logic [MASK_W-1:0] n);
    logic [MASK_W-1:0] m;
    logic [MASK_W-1:0] lim;
    m   = '0;
    lim = (n == '0) ? '0 : n - MASK_W'(1);
    for (int i = 0; i < int'(MASK_W); i++) begin
      if (m < lim) m = {m[MASK_W-2:0], 1'b1};
    end
    return m;
  endfunction

endpackage

// File: rtl/rand_mod_div.sv
// rand_mod_div: bit-serial restoring remainder unit, one dividend bit per
// cycle MSB first. done/rem are combinational and mark the final step, so
// the caller can register the finished remainder in that same cycle.
module rand_mod_div
  import rand_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned RANGE_W = DEF_RANGE_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [RANGE_W-1:0] divisor,
  output logic               done,
  output logic [RANGE_W-1:0] rem
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic               run_q, run_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RANGE_W-1:0] rem_q, rem_d;

  logic [CNT_W-1:0]   idx_c;
  logic [RANGE_W:0]   shifted_c;
  logic [RANGE_W-1:0] step_c;
  logic               last_c;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // The stored remainder is always < divisor, so the shifted value needs one
  // extra bit only transiently.
  always_comb begin
    idx_c     = CNT_W'(WIDTH - 1) - cnt_q;
    shifted_c = {rem_q, dividend[idx_c]};
    if (shifted_c >= {1'b0, divisor}) step_c = RANGE_W'(shifted_c - {1'b0, divisor});
    else                              step_c = RANGE_W'(shifted_c);
    last_c    = run_q && (cnt_q == CNT_W'(WIDTH - 1));
  end

  // Sequencing: start clears the remainder, then WIDTH steps run back to back.
  always_comb begin
    run_d = run_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    if (start) begin
      run_d = 1'b1;
      cnt_d = '0;
      rem_d = '0;
    end else if (run_q) begin
      rem_d = step_c;
      cnt_d = cnt_q + CNT_W'(1);
      if (last_c) run_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      rem_q <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
    end
  end

  assign done = last_c;
  assign rem  = step_c;

endmodule

// File: rtl/rand_draw.sv
// rand_draw: request-driven draw of a value in [0, N) from the LFSR source.
// Clocks the generator SHIFTS times, samples its word, and reduces it with a
// sequential remainder unit. Optional macro RAND_DRAW_UNBIASED_EN switches to
// rejection sampling with a modulo fallback after MAX_RETRY rejections.
module rand_draw
  import rand_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned RANGE_W   = DEF_RANGE_W,
  parameter int unsigned SHIFTS    = DEF_SHIFTS,
  parameter int unsigned MAX_RETRY = DEF_MAX_RETRY
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req,
  input  logic [RANGE_W-1:0] range_n,
  output logic               rnd_en,
  input  logic [WIDTH-1:0]   rnd_in,
  output logic               busy,
  output logic               valid,
  output logic [RANGE_W-1:0] value,
  output logic               error
);

  localparam int unsigned SH_W = $clog2(SHIFTS + 1);

  // Reject parameter sets the datapath cannot honour.
  if (SHIFTS < 1 || SHIFTS > WIDTH || RANGE_W > WIDTH || MAX_RETRY < 1) begin : g_bad_cfg
    $error("rand_draw: unsupported parameter set");
  end

  draw_state_t        state_q, state_d;
  logic [RANGE_W-1:0] n_q, n_d;
  logic [WIDTH-1:0]   word_q, word_d;
  logic [SH_W-1:0]    cnt_q, cnt_d;
  logic [RANGE_W-1:0] value_q, value_d;
  logic               rnd_en_q, rnd_en_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic               error_q, error_d;

  logic               div_start_c;
  logic               div_done_c;
  logic [RANGE_W-1:0] div_rem_c;

`ifdef RAND_DRAW_UNBIASED_EN
  localparam int unsigned RT_W = $clog2(MAX_RETRY + 1);
  logic [RT_W-1:0]    retry_q, retry_d;
  logic [RANGE_W-1:0] cand_c;

  // Candidate = sampled word masked down to the smallest power-of-two range.
  always_comb begin
    cand_c = RANGE_W'(word_q & WIDTH'(mask_for(MASK_W'(n_q))));
  end
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    word_d      = word_q;
    cnt_d       = cnt_q;
    value_d     = value_q;
    div_start_c = 1'b0;
`ifdef RAND_DRAW_UNBIASED_EN
    retry_d     = retry_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          n_d     = range_n;
          value_d = '0;
          cnt_d   = '0;
`ifdef RAND_DRAW_UNBIASED_EN
          retry_d = '0;
`endif
          if (range_n == '0) state_d = ST_DONE;
          else               state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        cnt_d = cnt_q + SH_W'(1);
        if (cnt_q == SH_W'(SHIFTS - 1)) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        word_d = rnd_in;
`ifdef RAND_DRAW_UNBIASED_EN
        state_d = ST_CHECK;
`else
        div_start_c = 1'b1;
        state_d     = ST_DIV;
`endif
      end
`ifdef RAND_DRAW_UNBIASED_EN
      ST_CHECK: begin
        if (cand_c < n_q) begin
          value_d = cand_c;
          state_d = ST_DONE;
        end else if (retry_q == RT_W'(MAX_RETRY)) begin
          div_start_c = 1'b1;
          state_d     = ST_DIV;
        end else begin
          retry_d = retry_q + RT_W'(1);
          cnt_d   = '0;
          state_d = ST_FILL;
        end
      end
`endif
      ST_DIV: begin
        if (div_done_c) begin
          value_d = div_rem_c;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    rnd_en_d = (state_d == ST_FILL);
    busy_d   = !((state_d == ST_IDLE) || (state_d == ST_DONE));
    valid_d  = (state_d == ST_DONE);
    error_d  = valid_d && (n_d == '0);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      n_q      <= '0;
      word_q   <= '0;
      cnt_q    <= '0;
      value_q  <= '0;
      rnd_en_q <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
`ifdef RAND_DRAW_UNBIASED_EN
      retry_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      word_q   <= word_d;
      cnt_q    <= cnt_d;
      value_q  <= value_d;
      rnd_en_q <= rnd_en_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
`ifdef RAND_DRAW_UNBIASED_EN
      retry_q  <= retry_d;
`endif
    end
  end

  rand_mod_div #(
    .WIDTH  (WIDTH),
    .RANGE_W(RANGE_W)
  ) u_div (
    .clk     (clk),
    .reset   (reset),
    .start   (div_start_c),
    .dividend(word_q),
    .divisor (n_q),
    .done    (div_done_c),
    .rem     (div_rem_c)
  );

  assign rnd_en = rnd_en_q;
  assign busy   = busy_q;
  assign valid  = valid_q;
  assign value  = value_q;
  assign error  = error_q;

endmodule

// File: tb/tb_rand_draw.sv
// tb_rand_draw: randomized self-checking bench for rand_draw against a
// draw-level reference model (word count, masking, modulo, latency formula).
module tb_rand_draw;

  localparam int W      = 32;
  localparam int SH     = 32;
  localparam int MR     = 4;
  localparam int BUDGET = 400;
  localparam logic [31:0] SEED = 32'hDEADBEEF;
`ifdef RAND_DRAW_UNBIASED_EN
  localparam int MAIN_VAL = 82;
  localparam int MAIN_LAT = 35;
`else
  localparam int MAIN_VAL = 34;
  localparam int MAIN_LAT = 66;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [7:0]  range_n;
  logic        rnd_en;
  logic [31:0] rnd_in;
  logic        busy;
  logic        valid;
  logic [7:0]  value;
  logic        error;

  logic        use_lfsr;
  logic        lfsr_load;
  logic [31:0] rnd_fix;
  logic [31:0] lfsr;

  int n_checks = 0;
  int n_pass   = 0;
  int en_first, en_last, obs_val;

  rand_draw dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .range_n(range_n),
    .rnd_en (rnd_en),
    .rnd_in (rnd_in),
    .busy   (busy),
    .valid  (valid),
    .value  (value),
    .error  (error)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ 32'hA3000000) : (x >> 1);
  endfunction

  // Bench-side generator: registered word, advances only when enabled.
  always @(posedge clk) begin
    if (lfsr_load)   lfsr <= SEED;
    else if (rnd_en) lfsr <= lfsr_next(lfsr);
  end

  assign rnd_in = use_lfsr ? lfsr : rnd_fix;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int mask_of(input int n);
    for (int k = 0; k < 31; k++) begin
      if ((2 ** k) - 1 >= n - 1) return (2 ** k) - 1;
    end
    return 32'h7FFFFFFF;
  endfunction

  // Expected outcome for one draw against a constant generator word.
  function automatic void ref_fixed(input logic [31:0] w, input int n,
                                    output int val, output int lat, output int fills);
    val   = int'(w % 32'(n));
    fills = 1;
    lat   = SH + 2 + W;
`ifdef RAND_DRAW_UNBIASED_EN
    if (int'(w & 32'(mask_of(n))) < n) begin
      val = int'(w & 32'(mask_of(n)));
      lat = SH + 3;
    end else begin
      fills = MR + 1;
      lat   = fills * (SH + 2) + W + 1;
    end
`endif
  endfunction

  // Expected outcome for one draw from a running generator state.
  function automatic void ref_live(input logic [31:0] s_in, input int n, output logic [31:0] s_out,
                                   output int val, output int lat, output int fills);
    logic [31:0] s;
    s     = s_in;
    fills = 0;
    val   = 0;
    lat   = 0;
    for (int t = 0; t <= MR; t++) begin
      for (int i = 0; i < SH; i++) s = lfsr_next(s);
      fills++;
`ifdef RAND_DRAW_UNBIASED_EN
      if (int'(s & 32'(mask_of(n))) < n) begin
        val = int'(s & 32'(mask_of(n)));
        lat = fills * (SH + 2) + 1;
        break;
      end
      if (t == MR) begin
        val = int'(s % 32'(n));
        lat = fills * (SH + 2) + W + 1;
      end
`else
      val = int'(s % 32'(n));
      lat = SH + 2 + W;
      break;
`endif
    end
    s_out = s;
  endfunction

  // Issue one request in cycle 0 and check the whole transaction.
  task automatic run_draw(input string tag, input int n, input int re1, input int re2,
                          input int exp_val, input int exp_lat, input int exp_err, input int exp_fills);
    int  cyc      = 0;
    int  en_cnt   = 0;
    int  busy_bad = 0;
    bit  seen     = 0;
    en_first = -1;
    en_last  = -1;
    obs_val  = -1;
    range_n  = 8'(n);
    req      = 1'b1;
    while (!seen && cyc < BUDGET) begin
      tick();
      cyc++;
      req = (cyc == re1) || (cyc == re2);
      if (req) range_n = 8'd7;
      if (rnd_en) begin
        en_cnt++;
        if (en_first < 0) en_first = cyc;
        en_last = cyc;
      end
      if (busy !== (cyc < exp_lat)) busy_bad++;
      if (valid) begin
        seen    = 1;
        obs_val = int'(value);
        check_eq({tag, "_lat"}, cyc, exp_lat);
        check_eq({tag, "_value"}, value, exp_val);
        check_eq({tag, "_error"}, error, exp_err);
      end
    end
    req = 1'b0;
    if (!seen) check_eq({tag, "_timeout"}, 0, 1);
    check_eq({tag, "_en_count"}, en_cnt, exp_fills * SH);
    check_eq({tag, "_busy_bad"}, busy_bad, 0);
    tick();
    check_eq({tag, "_pulse"}, valid, 0);
    check_eq({tag, "_hold"}, value, exp_val);
  endtask

  initial begin
    logic [31:0] w, ref_s, ref_s2;
    int n, ev, el, ef;

    reset     = 1'b1;
    req       = 1'b0;
    range_n   = '0;
    use_lfsr  = 1'b0;
    lfsr_load = 1'b1;
    rnd_fix   = 32'd1234;
    repeat (3) tick();
    check_eq("rst_rnd_en", rnd_en, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_value", value, 0);
    check_eq("rst_error", error, 0);
    reset     = 1'b0;
    lfsr_load = 1'b0;
    tick();

    // Main modulo case with fixed word 1234, N = 100.
    ref_fixed(32'd1234, 100, ev, el, ef);
    check_eq("model_main_val", ev, MAIN_VAL);
    run_draw("mod", 100, -1, -1, MAIN_VAL, MAIN_LAT, 0, ef);
    check_eq("mod_en_first", en_first, 1);
    check_eq("mod_en_last", en_last, SH);

    // Value holds while range_n moves with req low.
    range_n = 8'd200;
    repeat (3) tick();
    check_eq("hold_idle_value", value, MAIN_VAL);
    check_eq("hold_idle_valid", valid, 0);

    // Zero range: immediate error completion, generator untouched.
    run_draw("zero", 0, -1, -1, 0, 1, 1, 0);

    // Requests while busy are ignored.
    run_draw("busy", 100, 10, 40, MAIN_VAL, MAIN_LAT, 0, ef);

    // Reset in the middle of the division.
    range_n = 8'd100;
    req     = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      tick();
      req = 1'b0;
    end
    reset = 1'b1;
    tick();
    check_eq("mrst_busy", busy, 0);
    check_eq("mrst_valid", valid, 0);
    check_eq("mrst_value", value, 0);
    check_eq("mrst_rnd_en", rnd_en, 0);
    reset = 1'b0;
    tick();
    run_draw("after_rst", 100, -1, -1, MAIN_VAL, MAIN_LAT, 0, ef);

    // Directed words and boundary ranges, then random word/range pairs.
    for (int i = 0; i < 26; i++) begin
      case (i)
        0: begin w = 32'h41;       n = 100; end
        1: begin w = 32'hFF;       n = 100; end
        2: begin w = 32'hFFFFFFFF; n = 255; end
        3: begin w = 32'h0;        n = 7;   end
        4: begin w = $urandom;     n = 1;   end
        5: begin w = $urandom;     n = 255; end
        default: begin w = $urandom; n = $urandom_range(1, 255); end
      endcase
      rnd_fix = w;
      ref_fixed(w, n, ev, el, ef);
      run_draw($sformatf("fix%0d", i), n, -1, -1, ev, el, 0, ef);
    end

    // Live generator: 1000 draws with N = 37.
    use_lfsr  = 1'b1;
    lfsr_load = 1'b1;
    tick();
    lfsr_load = 1'b0;
    ref_s     = SEED;
    for (int d = 0; d < 1000; d++) begin
      ref_live(ref_s, 37, ref_s2, ev, el, ef);
      ref_s = ref_s2;
      run_draw("live", 37, -1, -1, ev, el, 0, ef);
      check_eq("live_lt37", (obs_val >= 0 && obs_val < 37), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rand_draw.md
# rand_draw

Consumer-side front end for the LFSR random source. On a client request it clocks the generator for a fresh word via the generator's clock-enable, captures the word, and reduces it to a value in [0, N). The reduction is sequential and has no divider in the critical path. Maze, word-pick and hangman logic call this block with a req/valid handshake instead of reading raw generator output.

## Interface
- WIDTH, 32: generator word width
- RANGE_W, 8: width of range bound and result
- SHIFTS, 32: generator shifts per draw (1..WIDTH)
- MAX_RETRY, 4: rejection retries before modulo fallback (used only with macro)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req  in  1  draw request; sampled only in IDLE
- range_n  in  RANGE_W  exclusive upper bound N; latched on accept
- rnd_en  out  1  clock-enable to the generator
- rnd_in  in  WIDTH  generator output word; registered in the generator
- busy  out  1  high from the cycle after accept until the cycle valid is high
- valid  out  1  one-cycle result strobe
- value  out  RANGE_W  result; held from valid until the next accept
- error  out  1  pulses with valid when N == 0

## Operation
- States: IDLE, FILL, SAMPLE, DIV, DONE (plus CHECK with macro).
- IDLE: when req=1, latch range_n into n_q and clear value.
  - n_q == 0: go to DONE with error set and value 0.
  - Otherwise clear the shift counter and go to FILL.
- FILL: rnd_en=1 every cycle; counter increments. After SHIFTS cycles, go to SAMPLE.
- SAMPLE: rnd_en=0; capture rnd_in into word_q. Without macro go to DIV; with macro go to CHECK.
- DIV: restoring division, one quotient bit per cycle, MSB first, over WIDTH cycles.
  - Remainder register is RANGE_W+1 bits.
  - Each cycle: rem = {rem, word bit}; if rem >= n_q then rem -= n_q.
  - After WIDTH cycles, value = rem[RANGE_W-1:0] (= word_q mod N); go to DONE.
- DONE: valid=1 for one cycle, then IDLE. busy falls in this cycle.
- req while busy is ignored. No queuing and no backpressure; the client must capture value on valid or before its next req.
- N=1 runs the full sequence and returns 0.
- Reset in any state: return to IDLE. rnd_en, busy, valid and error go to 0; value goes to 0; the counter clears.

## Timing
Cycle 0 is the cycle in which req is sampled high in IDLE.
- rnd_en is high in cycles 1..SHIFTS.
- SAMPLE is cycle SHIFTS+1.
- DIV covers cycles SHIFTS+2 .. SHIFTS+1+WIDTH.
- valid is high in cycle SHIFTS+2+WIDTH. With defaults this is cycle 66.
- N=0: valid and error are high in cycle 1; rnd_en is never asserted.
- The next req is accepted at the earliest in the cycle after valid.
- All outputs are registered. Reset value of every output is 0.

## Configuration
- RAND_DRAW_UNBIASED_EN defined: rejection sampling replaces modulo.
  - CHECK state, one cycle: mask = smallest 2^k−1 >= N−1; cand = word_q & mask.
  - cand < N: value = cand, go to DONE. Valid lands in cycle SHIFTS+3.
  - Otherwise increment the retry counter and go to FILL again.
  - After MAX_RETRY rejections, take the DIV path on the last word.
- Undefined: CHECK state and retry counter are absent; every draw uses modulo with the fixed latency above.

## Structure
- rand_pkg:
  - state enum draw_state_t.
  - Default constants for WIDTH, SHIFTS and MAX_RETRY.
  - Function mask_for(N).
- Sub-module rand_mod_div: sequential restoring remainder unit.
  - Ports: start, dividend (WIDTH), divisor (RANGE_W), done, rem (RANGE_W).
  - Instantiated once; the FSM sequences it.

## Test plan
- Modulo: bench holds rnd_in=32'd1234 constant, range_n=100, req at cycle 0 -> rnd_en high in cycles 1–32 only; valid in cycle 66 with value=34; error=0.
- Zero range: range_n=0, req -> valid and error in cycle 1, value=0, rnd_en never high.
- Busy and hold: req pulsed again in cycles 10 and 40 -> ignored; single valid in cycle 66. Then range_n changes with req low -> value still holds 34.
- Reset mid-DIV: assert reset in cycle 50 -> next cycle busy=0, valid=0, value=0, rnd_en=0. New req completes normally.
- Live generator: connect the LFSR (seed 32'hDEADBEEF, clk_en=rnd_en), N=37, 1000 draws -> every value < 37, each result matches a reference model of word mod 37.
- RAND_DRAW_UNBIASED_EN: rnd_in=32'h41, N=100 -> value 65 in cycle 35. rnd_in=32'hFF, N=100 -> 4 refills (cand 127 each), then modulo gives 55.
